// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: operation codes, branch-compare
// codes and bit-count unit selects.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] ALU_ADD    = 7'd0;
  localparam logic [6:0] ALU_SUB    = 7'd1;
  localparam logic [6:0] ALU_SLL    = 7'd2;
  localparam logic [6:0] ALU_SLT    = 7'd3;
  localparam logic [6:0] ALU_SLTU   = 7'd4;
  localparam logic [6:0] ALU_XOR    = 7'd5;
  localparam logic [6:0] ALU_SRL    = 7'd6;
  localparam logic [6:0] ALU_SRA    = 7'd7;
  localparam logic [6:0] ALU_OR     = 7'd8;
  localparam logic [6:0] ALU_AND    = 7'd9;
  localparam logic [6:0] ALU_MUL    = 7'd10;
  localparam logic [6:0] ALU_MULH   = 7'd11;
  localparam logic [6:0] ALU_MULHSU = 7'd12;
  localparam logic [6:0] ALU_MULHU  = 7'd13;
  localparam logic [6:0] ALU_ANDN   = 7'd14;
  localparam logic [6:0] ALU_ORN    = 7'd15;
  localparam logic [6:0] ALU_XNOR   = 7'd16;
  localparam logic [6:0] ALU_CLZ    = 7'd17;
  localparam logic [6:0] ALU_CTZ    = 7'd18;
  localparam logic [6:0] ALU_CPOP   = 7'd19;
  localparam logic [6:0] ALU_MAX    = 7'd20;
  localparam logic [6:0] ALU_MAXU   = 7'd21;
  localparam logic [6:0] ALU_MIN    = 7'd22;
  localparam logic [6:0] ALU_MINU   = 7'd23;
  localparam logic [6:0] ALU_SEXTB  = 7'd24;
  localparam logic [6:0] ALU_SEXTH  = 7'd25;
  localparam logic [6:0] ALU_ZEXTH  = 7'd26;
  localparam logic [6:0] ALU_ROL    = 7'd27;
  localparam logic [6:0] ALU_ROR    = 7'd28;
  localparam logic [6:0] ALU_ORCB   = 7'd29;
  localparam logic [6:0] ALU_REV8   = 7'd30;
  localparam logic [6:0] ALU_PASS_B = 7'd31;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [1:0] BC_CLZ  = 2'd0;
  localparam logic [1:0] BC_CTZ  = 2'd1;
  localparam logic [1:0] BC_CPOP = 2'd2;

endpackage

// File: rtl/alu_bitcount.sv
// Combinational leading-zero / trailing-zero / population count on a 32-bit word.
// An all-zero input yields 32 for both CLZ and CTZ.
module alu_bitcount
  import alu_pkg::*;
(
  input  logic [1:0]      i_sel,
  input  logic [XLEN-1:0] i_data,
  output logic [5:0]      o_count
);

  logic [5:0] w_clz;
  logic [5:0] w_ctz;
  logic [5:0] w_cpop;
  logic       w_lead_hit;
  logic       w_trail_hit;

  always_comb begin
    w_clz       = 6'd0;
    w_ctz       = 6'd0;
    w_cpop      = 6'd0;
    w_lead_hit  = 1'b0;
    w_trail_hit = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (i_data[i]) w_cpop = w_cpop + 6'd1;
      // Scan from both ends at once; counting stops at the first set bit.
      if (i_data[XLEN-1-i]) w_lead_hit = 1'b1;
      else if (!w_lead_hit) w_clz = w_clz + 6'd1;
      if (i_data[i]) w_trail_hit = 1'b1;
      else if (!w_trail_hit) w_ctz = w_ctz + 6'd1;
    end
  end

  always_comb begin
    case (i_sel)
      BC_CLZ:  o_count = w_clz;
      BC_CTZ:  o_count = w_ctz;
      BC_CPOP: o_count = w_cpop;
      default: o_count = 6'd0;
    endcase
  end

endmodule

// File: rtl/alu_single_cycle.sv
// RV32 execute-stage ALU (RV32I, RV32M multiplies, Zbb) plus branch compare,
// with both results registered once per clock.
module alu_single_cycle
  import alu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [6:0]      alu_cmd,
  input  logic [2:0]      zero_cmd,
  output logic [XLEN-1:0] rd_data_o,
  output logic            zero_o
);

  logic [4:0]      w_shamt;
  logic [5:0]      w_rot_back;
  logic            w_lt;
  logic            w_ltu;
  logic [XLEN-1:0] w_sra;
  logic [XLEN-1:0] w_rol;
  logic [XLEN-1:0] w_ror;
  logic [XLEN-1:0] w_orcb;
  logic [XLEN-1:0] w_rev8;
  logic [1:0]      w_bc_sel;
  logic [5:0]      w_bc_count;
  logic            w_mul_a_signed;
  logic            w_mul_b_signed;
  logic [32:0]     w_mul_a;
  logic [32:0]     w_mul_b;
  logic [63:0]     w_prod;
  logic [XLEN-1:0] w_result;
  logic            w_taken;
  logic [XLEN-1:0] r_rd_data;
  logic            r_zero;

  assign w_shamt    = rs2_data_i[4:0];
  assign w_rot_back = 6'd32 - {1'b0, w_shamt};
  assign w_lt       = $signed(rs1_data_i) < $signed(rs2_data_i);
  assign w_ltu      = rs1_data_i < rs2_data_i;
  assign w_sra      = $signed(rs1_data_i) >>> w_shamt;
  // A zero amount shifts the back half out entirely, leaving rs1 unchanged.
  assign w_rol      = (rs1_data_i << w_shamt) | (rs1_data_i >> w_rot_back);
  assign w_ror      = (rs1_data_i >> w_shamt) | (rs1_data_i << w_rot_back);
  assign w_rev8     = {rs1_data_i[7:0], rs1_data_i[15:8], rs1_data_i[23:16], rs1_data_i[31:24]};

  always_comb begin
    w_orcb = '0;
    for (int i = 0; i < 4; i++) begin
      w_orcb[i*8 +: 8] = (rs1_data_i[i*8 +: 8] != 8'h00) ? 8'hFF : 8'h00;
    end
  end

  assign w_bc_sel = (alu_cmd == ALU_CTZ)  ? BC_CTZ  :
                    (alu_cmd == ALU_CPOP) ? BC_CPOP : BC_CLZ;

  alu_bitcount u_bitcount (
    .i_sel   (w_bc_sel),
    .i_data  (rs1_data_i),
    .o_count (w_bc_count)
  );

  // One 33x33 signed multiplier; the extra operand bit selects signed/unsigned.
  // Only the low 64 product bits are kept, which are exact for every variant.
  assign w_mul_a_signed = (alu_cmd == ALU_MULH) || (alu_cmd == ALU_MULHSU);
  assign w_mul_b_signed = (alu_cmd == ALU_MULH);
  assign w_mul_a = {w_mul_a_signed & rs1_data_i[31], rs1_data_i};
  assign w_mul_b = {w_mul_b_signed & rs2_data_i[31], rs2_data_i};
  assign w_prod  = $signed({{31{w_mul_a[32]}}, w_mul_a}) * $signed({{31{w_mul_b[32]}}, w_mul_b});

  always_comb begin
    case (alu_cmd)
      ALU_ADD:    w_result = rs1_data_i + rs2_data_i;
      ALU_SUB:    w_result = rs1_data_i - rs2_data_i;
      ALU_SLL:    w_result = rs1_data_i << w_shamt;
      ALU_SLT:    w_result = {31'd0, w_lt};
      ALU_SLTU:   w_result = {31'd0, w_ltu};
      ALU_XOR:    w_result = rs1_data_i ^ rs2_data_i;
      ALU_SRL:    w_result = rs1_data_i >> w_shamt;
      ALU_SRA:    w_result = w_sra;
      ALU_OR:     w_result = rs1_data_i | rs2_data_i;
      ALU_AND:    w_result = rs1_data_i & rs2_data_i;
      ALU_MUL:    w_result = w_prod[31:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  w_result = w_prod[63:32];
      ALU_ANDN:   w_result = rs1_data_i & ~rs2_data_i;
      ALU_ORN:    w_result = rs1_data_i | ~rs2_data_i;
      ALU_XNOR:   w_result = ~(rs1_data_i ^ rs2_data_i);
      ALU_CLZ,
      ALU_CTZ,
      ALU_CPOP:   w_result = {26'd0, w_bc_count};
      ALU_MAX:    w_result = w_lt  ? rs2_data_i : rs1_data_i;
      ALU_MAXU:   w_result = w_ltu ? rs2_data_i : rs1_data_i;
      ALU_MIN:    w_result = w_lt  ? rs1_data_i : rs2_data_i;
      ALU_MINU:   w_result = w_ltu ? rs1_data_i : rs2_data_i;
      ALU_SEXTB:  w_result = {{24{rs1_data_i[7]}}, rs1_data_i[7:0]};
      ALU_SEXTH:  w_result = {{16{rs1_data_i[15]}}, rs1_data_i[15:0]};
      ALU_ZEXTH:  w_result = {16'd0, rs1_data_i[15:0]};
      ALU_ROL:    w_result = w_rol;
      ALU_ROR:    w_result = w_ror;
      ALU_ORCB:   w_result = w_orcb;
      ALU_REV8:   w_result = w_rev8;
      ALU_PASS_B: w_result = rs2_data_i;
      default:    w_result = '0;
    endcase
  end

  always_comb begin
    case (zero_cmd)
      BR_EQ:   w_taken = (rs1_data_i == rs2_data_i);
      BR_NE:   w_taken = (rs1_data_i != rs2_data_i);
      BR_LT:   w_taken = w_lt;
      BR_GE:   w_taken = ~w_lt;
      BR_LTU:  w_taken = w_ltu;
      BR_GEU:  w_taken = ~w_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_data <= '0;
      r_zero    <= 1'b0;
    end else begin
      r_rd_data <= w_result;
      r_zero    <= w_taken;
    end
  end

  assign rd_data_o = r_rd_data;
  assign zero_o    = r_zero;

endmodule

// File: tb/tb_alu_single_cycle.sv
// Directed-vector bench for alu_single_cycle: a table of hand-computed results
// plus hand-written reset and hold sequences.
module tb_alu_single_cycle;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [6:0]  alu_cmd;
  logic [2:0]  zero_cmd;
  logic [31:0] rd_data_o;
  logic        zero_o;

  int n_cmp;
  int n_err;

  typedef struct {
    string       name;
    logic [6:0]  cmd;
    logic [2:0]  zc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  alu_single_cycle dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .alu_cmd    (alu_cmd),
    .zero_cmd   (zero_cmd),
    .rd_data_o  (rd_data_o),
    .zero_o     (zero_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic add(input string name, input logic [6:0] cmd, input logic [2:0] zc,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] rd, input logic z);
    vec_t v;
    v.name = name; v.cmd = cmd; v.zc = zc; v.a = a; v.b = b; v.rd = rd; v.z = z;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] exp_rd, input logic exp_z);
    n_cmp++;
    if (rd_data_o !== exp_rd || zero_o !== exp_z) begin
      n_err++;
      $display("FAIL %s: got rd=%08h z=%b, want rd=%08h z=%b", name, rd_data_o, zero_o, exp_rd, exp_z);
    end
  endtask

  task automatic drive(input logic [6:0] cmd, input logic [2:0] zc,
                       input logic [31:0] a, input logic [31:0] b);
    alu_cmd = cmd; zero_cmd = zc; rs1_data_i = a; rs2_data_i = b;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_i = 1'b0;
    drive(7'd0, 3'b010, 32'h0, 32'h0);

    //   name        cmd    zc      rs1           rs2           rd            z
    add("add_wrap",  7'd0,  3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    add("sub",       7'd1,  3'b001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1);
    add("slt",       7'd3,  3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1);
    add("sltu",      7'd4,  3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    add("sll",       7'd2,  3'b010, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0);
    add("sra",       7'd7,  3'b101, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0);
    add("srl",       7'd6,  3'b111, 32'h80000000, 32'h00000024, 32'h08000000, 1'b1);
    add("ror",       7'd28, 3'b011, 32'h00000001, 32'h00000001, 32'h80000000, 1'b0);
    add("rol",       7'd27, 3'b000, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0);
    add("ror_zero",  7'd28, 3'b010, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0);
    add("mul",       7'd10, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    add("mulh",      7'd11, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    add("mulhu",     7'd13, 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    add("mulhsu",    7'd12, 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    add("mulhsu_2",  7'd12, 3'b010, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    add("mulh_min",  7'd11, 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1);
    add("clz",       7'd17, 3'b010, 32'h00010000, 32'h0,        32'h0000000F, 1'b0);
    add("ctz_zero",  7'd18, 3'b010, 32'h00000000, 32'hFFFFFFFF, 32'h00000020, 1'b0);
    add("cpop",      7'd19, 3'b010, 32'hF0F0F0F0, 32'h0,        32'h00000010, 1'b0);
    add("clz_zero",  7'd17, 3'b010, 32'h00000000, 32'h0,        32'h00000020, 1'b0);
    add("ctz",       7'd18, 3'b010, 32'h00010000, 32'h0,        32'h00000010, 1'b0);
    add("rev8",      7'd30, 3'b010, 32'h12345678, 32'h0,        32'h78563412, 1'b0);
    add("orcb",      7'd29, 3'b010, 32'h00120000, 32'h0,        32'h00FF0000, 1'b0);
    add("sextb",     7'd24, 3'b010, 32'h00000080, 32'h0,        32'hFFFFFF80, 1'b0);
    add("sexth",     7'd25, 3'b010, 32'h00008001, 32'h0,        32'hFFFF8001, 1'b0);
    add("zexth",     7'd26, 3'b010, 32'hFFFF1234, 32'h0,        32'h00001234, 1'b0);
    add("andn",      7'd14, 3'b010, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF000F000, 1'b0);
    add("orn",       7'd15, 3'b010, 32'h00000000, 32'hFFFF0000, 32'h0000FFFF, 1'b0);
    add("xnor",      7'd16, 3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 1'b0);
    add("max",       7'd20, 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
    add("maxu",      7'd21, 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0);
    add("min",       7'd22, 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0);
    add("minu",      7'd23, 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
    add("xor",       7'd5,  3'b010, 32'h0000000F, 32'h000000FF, 32'h000000F0, 1'b0);
    add("or",        7'd8,  3'b010, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0);
    add("and",       7'd9,  3'b010, 32'h0000000F, 32'h000000FF, 32'h0000000F, 1'b0);
    add("pass_b",    7'd31, 3'b010, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    add("illegal100",7'd100,3'b010, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0);
    add("illegal32", 7'd32, 3'b000, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1);
    add("bge_min",   7'd0,  3'b101, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0);
    add("bgeu_min",  7'd0,  3'b111, 32'h80000000, 32'h00000000, 32'h80000000, 1'b1);

    // Asynchronous reset from power-up, before any clock edge matters.
    #1 rst_i = 1'b1;
    #1 check("reset_init", 32'h0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i].cmd, vecs[i].zc, vecs[i].a, vecs[i].b);
      @(posedge clk_i);
      #1 check(vecs[i].name, vecs[i].rd, vecs[i].z);
    end

    // Reset asserted mid-cycle with an ADD pending clears outputs before the next edge.
    @(negedge clk_i);
    drive(7'd0, 3'b000, 32'h00000001, 32'h00000001);
    @(posedge clk_i);
    #1 check("pre_reset", 32'h00000002, 1'b1);
    @(negedge clk_i);
    drive(7'd0, 3'b000, 32'h00000003, 32'h00000003);
    #2 rst_i = 1'b1;
    #1 check("reset_async", 32'h0, 1'b0);
    @(posedge clk_i);
    #1 check("reset_held", 32'h0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 check("reset_release", 32'h0, 1'b0);
    @(posedge clk_i);
    #1 check("first_after_reset", 32'h00000006, 1'b1);
    @(posedge clk_i);
    #1 check("hold_inputs", 32'h00000006, 1'b1);

    // Back-to-back ops: each result reflects only the inputs of its own edge.
    @(negedge clk_i);
    drive(7'd1, 3'b110, 32'h00000001, 32'h00000002);
    @(posedge clk_i);
    #1 check("b2b_sub", 32'hFFFFFFFF, 1'b1);
    drive(7'd10, 3'b001, 32'h00010000, 32'h00010000);
    @(posedge clk_i);
    #1 check("b2b_mul", 32'h00000000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
